ysyx_24080006_axi_arbiter: RTL and testbench

YSYX_24080006_AXI_ARBITER -- requirements
Module: ysyx_24080006_axi_arbiter

---
 rtl/ysyx_24080006_axi_arbiter_pkg.sv | 31 +++
 rtl/ysyx_24080006_axi_arbiter_if.sv | 56 +++++
 rtl/ysyx_24080006_axi_arbiter.sv | 148 ++++++++++++++
 tb/tb_ysyx_24080006_axi_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24080006_axi_arbiter_pkg.sv
// Shared types and AXI constants for the IFU/LSU arbiter in front of the CLINT crossbar.
package ysyx_24080006_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } arb_state_e;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic [3:0] owner_id(input owner_e own, input logic [3:0] ifu_id,
                                            input logic [3:0] lsu_id);
        return (own == OWN_LSU) ? lsu_id : ifu_id;
    endfunction

endpackage

// File: rtl/ysyx_24080006_axi_arbiter_if.sv
// AXI4 bundle (32-bit address/data, 4-bit ID); master drives requests, slave drives responses.
interface ysyx_24080006_axi;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        rlast;
    logic [3:0]  rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        output rready,
        input  awready, wready, bvalid, bresp, bid,
        input  arready, rvalid, rresp, rdata, rlast, rid
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        input  rready,
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rresp, rdata, rlast, rid
    );
endinterface

// File: rtl/ysyx_24080006_axi_arbiter.sv
// Merges IFU (read-only) and LSU AXI masters onto one downstream port, one transaction at a time.
// LSU writes beat LSU reads beat IFU reads; the owner's channels pass through combinationally.
module ysyx_24080006_axi_arbiter
    import ysyx_24080006_pkg::*;
#(
    parameter logic [3:0] IFU_ID = 4'h0,
    parameter logic [3:0] LSU_ID = 4'h1
) (
    input  logic               clock,
    input  logic               reset,
    ysyx_24080006_axi.slave    ifu,
    ysyx_24080006_axi.slave    lsu,
    ysyx_24080006_axi.master   axi
);

    arb_state_e r_state;
    owner_e     r_owner;
    logic       r_aw_done;
    logic       r_w_done;

    logic w_sel_lsu;
    logic w_own_arvalid;
    logic w_own_rready;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_fin;
    logic w_w_fin;
    logic w_unused;

    assign w_sel_lsu     = (r_owner == OWN_LSU);
    assign w_own_arvalid = w_sel_lsu ? lsu.arvalid : ifu.arvalid;
    assign w_own_rready  = w_sel_lsu ? lsu.rready  : ifu.rready;
    assign w_aw_hs       = lsu.awvalid & ~r_aw_done & axi.awready;
    assign w_w_hs        = lsu.wvalid  & ~r_w_done  & axi.wready;
    assign w_aw_fin      = r_aw_done | w_aw_hs;
    assign w_w_fin       = r_w_done  | (w_w_hs & lsu.wlast);

    // IFU write channels and upstream IDs are never consumed.
    assign w_unused = &{1'b0, ifu.awvalid, ifu.awaddr, ifu.awid, ifu.awlen, ifu.awsize,
                        ifu.awburst, ifu.wvalid, ifu.wdata, ifu.wstrb, ifu.wlast, ifu.bready,
                        ifu.arid, lsu.arid, lsu.awid};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_owner   <= OWN_IFU;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (lsu.awvalid) begin
                        r_owner <= OWN_LSU;
                        r_state <= WR_REQ;
                    end else if (lsu.arvalid) begin
                        r_owner <= OWN_LSU;
                        r_state <= RD_ADDR;
                    end else if (ifu.arvalid) begin
                        r_owner <= OWN_IFU;
                        r_state <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (w_own_arvalid && axi.arready) r_state <= RD_DATA;
                end
                RD_DATA: begin
                    if (axi.rvalid && w_own_rready && axi.rlast) r_state <= IDLE;
                end
                WR_REQ: begin
                    // AW and W complete in either order; flags drop as the response phase opens.
                    if (w_aw_fin && w_w_fin) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= WR_RESP;
                    end else begin
                        if (w_aw_hs)              r_aw_done <= 1'b1;
                        if (w_w_hs && lsu.wlast)  r_w_done  <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (axi.bvalid && lsu.bready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ifu.awready = '0; ifu.wready = '0; ifu.bvalid = '0; ifu.bresp = '0; ifu.bid = '0;
        ifu.arready = '0; ifu.rvalid = '0; ifu.rresp = '0; ifu.rdata = '0; ifu.rlast = '0;
        ifu.rid     = '0;
        lsu.awready = '0; lsu.wready = '0; lsu.bvalid = '0; lsu.bresp = '0; lsu.bid = '0;
        lsu.arready = '0; lsu.rvalid = '0; lsu.rresp = '0; lsu.rdata = '0; lsu.rlast = '0;
        lsu.rid     = '0;
        axi.awvalid = '0; axi.awaddr = '0; axi.awid = '0; axi.awlen = '0; axi.awsize = '0;
        axi.awburst = '0; axi.wvalid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = '0;
        axi.bready  = '0; axi.arvalid = '0; axi.araddr = '0; axi.arid = '0; axi.arlen = '0;
        axi.arsize  = '0; axi.arburst = '0; axi.rready = '0;

        // Reset masks the mux so a transaction cut short shows nothing while state unwinds.
        if (!reset) begin
            case (r_state)
                RD_ADDR: begin
                    axi.arvalid = w_own_arvalid;
                    axi.araddr  = w_sel_lsu ? lsu.araddr  : ifu.araddr;
                    axi.arlen   = w_sel_lsu ? lsu.arlen   : ifu.arlen;
                    axi.arsize  = w_sel_lsu ? lsu.arsize  : ifu.arsize;
                    axi.arburst = w_sel_lsu ? lsu.arburst : ifu.arburst;
                    axi.arid    = owner_id(r_owner, IFU_ID, LSU_ID);
                    if (w_sel_lsu) lsu.arready = axi.arready;
                    else           ifu.arready = axi.arready;
                end
                RD_DATA: begin
                    axi.rready = w_own_rready;
                    if (w_sel_lsu) begin
                        lsu.rvalid = axi.rvalid; lsu.rdata = axi.rdata; lsu.rresp = axi.rresp;
                        lsu.rlast  = axi.rlast;  lsu.rid   = axi.rid;
                    end else begin
                        ifu.rvalid = axi.rvalid; ifu.rdata = axi.rdata; ifu.rresp = axi.rresp;
                        ifu.rlast  = axi.rlast;  ifu.rid   = axi.rid;
                    end
                end
                WR_REQ: begin
                    axi.awvalid = lsu.awvalid & ~r_aw_done;
                    axi.awaddr  = lsu.awaddr;
                    axi.awid    = LSU_ID;
                    axi.awlen   = lsu.awlen;
                    axi.awsize  = lsu.awsize;
                    axi.awburst = lsu.awburst;
                    lsu.awready = axi.awready & ~r_aw_done;
                    axi.wvalid  = lsu.wvalid & ~r_w_done;
                    axi.wdata   = lsu.wdata;
                    axi.wstrb   = lsu.wstrb;
                    axi.wlast   = lsu.wlast;
                    lsu.wready  = axi.wready & ~r_w_done;
                end
                WR_RESP: begin
                    lsu.bvalid = axi.bvalid;
                    lsu.bresp  = axi.bresp;
                    lsu.bid    = axi.bid;
                    axi.bready = lsu.bready;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_axi_arbiter.sv
// Directed bench: a transaction-level model of the arbiter is checked every cycle,
// plus literal expectations pinned at key points of each scenario.
module tb_ysyx_24080006_axi_arbiter;
    import ysyx_24080006_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_24080006_axi ifu_b ();
    ysyx_24080006_axi lsu_b ();
    ysyx_24080006_axi axi_b ();

    ysyx_24080006_axi_arbiter #(.IFU_ID(4'h0), .LSU_ID(4'h1)) dut (
        .clock(clk), .reset(rst), .ifu(ifu_b), .lsu(lsu_b), .axi(axi_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
        end
    endtask

    // Model: one transaction record {active, write, owner is lsu, addr accepted, data accepted}.
    bit m_act, m_wr, m_lsu, m_aok, m_wok;
    int ifu_beats = 0, lsu_beats = 0, aw_hs_n = 0, w_hs_n = 0;

    logic        e_ifu_arready, e_lsu_arready, e_lsu_awready, e_lsu_wready;
    logic        e_axi_arvalid, e_axi_awvalid, e_axi_wvalid, e_axi_rready, e_axi_bready;
    logic        e_ifu_rvalid, e_lsu_rvalid, e_lsu_bvalid, e_rphase;
    logic [31:0] e_araddr, e_ifu_rdata, e_lsu_rdata;
    logic [16:0] e_arctl;
    logic [5:0]  e_rsp;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid_ready",
                {ifu_b.arready, ifu_b.rvalid, ifu_b.awready, ifu_b.wready, ifu_b.bvalid,
                 lsu_b.arready, lsu_b.rvalid, lsu_b.awready, lsu_b.wready, lsu_b.bvalid,
                 axi_b.arvalid, axi_b.rready, axi_b.awvalid, axi_b.wvalid, axi_b.bready}, 32'h0);
            {m_act, m_wr, m_lsu, m_aok, m_wok} = '0;
        end else begin
            {e_ifu_arready, e_lsu_arready, e_lsu_awready, e_lsu_wready} = '0;
            {e_axi_arvalid, e_axi_awvalid, e_axi_wvalid, e_axi_rready, e_axi_bready} = '0;
            {e_ifu_rvalid, e_lsu_rvalid, e_lsu_bvalid, e_rphase} = '0;
            e_araddr = '0; e_arctl = '0; e_ifu_rdata = '0; e_lsu_rdata = '0; e_rsp = '0;
            if (m_act && !m_wr && !m_aok) begin
                e_axi_arvalid = m_lsu ? lsu_b.arvalid : ifu_b.arvalid;
                e_araddr      = m_lsu ? lsu_b.araddr  : ifu_b.araddr;
                e_arctl       = m_lsu ? {4'h1, lsu_b.arlen, lsu_b.arsize, lsu_b.arburst}
                                      : {4'h0, ifu_b.arlen, ifu_b.arsize, ifu_b.arburst};
                if (m_lsu) e_lsu_arready = axi_b.arready; else e_ifu_arready = axi_b.arready;
            end else if (m_act && !m_wr) begin
                e_rphase     = 1'b1;
                e_axi_rready = m_lsu ? lsu_b.rready : ifu_b.rready;
                if (m_lsu) begin
                    e_lsu_rvalid = axi_b.rvalid; e_lsu_rdata = axi_b.rdata;
                    e_rsp = {3'b000, axi_b.rresp, axi_b.rlast};
                end else begin
                    e_ifu_rvalid = axi_b.rvalid; e_ifu_rdata = axi_b.rdata;
                    e_rsp = {axi_b.rresp, axi_b.rlast, 3'b000};
                end
            end else if (m_act && !(m_aok && m_wok)) begin
                e_axi_awvalid = lsu_b.awvalid && !m_aok;
                e_axi_wvalid  = lsu_b.wvalid && !m_wok;
                e_lsu_awready = axi_b.awready && !m_aok;
                e_lsu_wready  = axi_b.wready && !m_wok;
            end else if (m_act) begin
                e_lsu_bvalid = axi_b.bvalid;
                e_axi_bready = lsu_b.bready;
            end

            chk("ifu_arready", ifu_b.arready, e_ifu_arready);
            chk("lsu_arready", lsu_b.arready, e_lsu_arready);
            chk("lsu_awready", lsu_b.awready, e_lsu_awready);
            chk("lsu_wready",  lsu_b.wready,  e_lsu_wready);
            chk("ifu_write_side", {ifu_b.awready, ifu_b.wready, ifu_b.bvalid}, 32'h0);
            chk("axi_arvalid", axi_b.arvalid, e_axi_arvalid);
            chk("axi_awvalid", axi_b.awvalid, e_axi_awvalid);
            chk("axi_wvalid",  axi_b.wvalid,  e_axi_wvalid);
            chk("axi_rready",  axi_b.rready,  e_axi_rready);
            chk("axi_bready",  axi_b.bready,  e_axi_bready);
            chk("ifu_rvalid",  ifu_b.rvalid,  e_ifu_rvalid);
            chk("lsu_rvalid",  lsu_b.rvalid,  e_lsu_rvalid);
            chk("lsu_bvalid",  lsu_b.bvalid,  e_lsu_bvalid);
            if (e_axi_arvalid) begin
                chk("axi_araddr", axi_b.araddr, e_araddr);
                chk("axi_arctl", {15'b0, axi_b.arid, axi_b.arlen, axi_b.arsize, axi_b.arburst},
                    {15'b0, e_arctl});
            end
            if (e_axi_awvalid) begin
                chk("axi_awaddr", axi_b.awaddr, lsu_b.awaddr);
                chk("axi_awctl", {axi_b.awid, axi_b.awlen, axi_b.awsize, axi_b.awburst},
                    {4'h1, lsu_b.awlen, lsu_b.awsize, lsu_b.awburst});
            end
            if (e_axi_wvalid) begin
                chk("axi_wdata", axi_b.wdata, lsu_b.wdata);
                chk("axi_wctl", {axi_b.wstrb, axi_b.wlast}, {lsu_b.wstrb, lsu_b.wlast});
            end
            if (e_rphase) begin
                chk("ifu_rdata", ifu_b.rdata, e_ifu_rdata);
                chk("lsu_rdata", lsu_b.rdata, e_lsu_rdata);
                chk("r_resp_last", {ifu_b.rresp, ifu_b.rlast, lsu_b.rresp, lsu_b.rlast}, e_rsp);
            end
            if (e_lsu_bvalid) chk("lsu_bresp", lsu_b.bresp, axi_b.bresp);

            if (ifu_b.rvalid && ifu_b.rready) ifu_beats++;
            if (lsu_b.rvalid && lsu_b.rready) lsu_beats++;
            if (axi_b.awvalid && axi_b.awready) aw_hs_n++;
            if (axi_b.wvalid && axi_b.wready) w_hs_n++;

            if (!m_act) begin
                m_aok = 0; m_wok = 0;
                if (lsu_b.awvalid)      begin m_act = 1; m_wr = 1; m_lsu = 1; end
                else if (lsu_b.arvalid) begin m_act = 1; m_wr = 0; m_lsu = 1; end
                else if (ifu_b.arvalid) begin m_act = 1; m_wr = 0; m_lsu = 0; end
            end else if (!m_wr && !m_aok) begin
                if (e_axi_arvalid && axi_b.arready) m_aok = 1;
            end else if (!m_wr) begin
                if (axi_b.rvalid && e_axi_rready && axi_b.rlast) m_act = 0;
            end else if (!(m_aok && m_wok)) begin
                if (e_axi_awvalid && axi_b.awready) m_aok = 1;
                if (e_axi_wvalid && axi_b.wready && lsu_b.wlast) m_wok = 1;
            end else if (axi_b.bvalid && e_axi_bready) begin
                m_act = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ev(input int ev, input string nm);
        int n;
        bit hit;
        n = 0;
        do begin
            @(negedge clk);
            hit = (ev == 0) ? axi_b.arvalid : (ev == 1) ? axi_b.wvalid : axi_b.awvalid;
            n++;
        end while (!hit && n < 100);
        chk({"wait_", nm}, {31'b0, hit}, 32'h1);
    endtask

    task automatic run_read(input bit own_lsu, input logic [31:0] exp_addr,
                            input logic [3:0] exp_id, input int ar_dly, input int nbeats,
                            input logic [31:0] base, input logic [1:0] resp, input bit poke_ifu);
        wait_ev(0, "ar");
        chk("ar_id_lit", axi_b.arid, exp_id);
        chk("ar_addr_lit", axi_b.araddr, exp_addr);
        cyc();
        repeat (ar_dly) cyc();
        axi_b.arready = 1'b1;
        cyc();
        axi_b.arready = 1'b0;
        if (own_lsu) lsu_b.arvalid = 1'b0; else ifu_b.arvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            axi_b.rvalid = 1'b1;
            axi_b.rdata  = base + i;
            axi_b.rresp  = resp;
            axi_b.rlast  = (i == nbeats - 1);
            if (poke_ifu && i == 1) begin
                ifu_b.arvalid = 1'b1;
                ifu_b.araddr  = 32'h3000_0200;
            end
            @(negedge clk);
            chk("r_data_lit", own_lsu ? lsu_b.rdata : ifu_b.rdata, base + i);
            chk("r_resp_lit", own_lsu ? lsu_b.rresp : ifu_b.rresp, resp);
            chk("r_other_lit", own_lsu ? ifu_b.rvalid : lsu_b.rvalid, 32'h0);
            cyc();
        end
        axi_b.rvalid = 1'b0;
        axi_b.rlast  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "watchdog");
    end

    int lb0, aw0, w0;

    initial begin
        ifu_b.awvalid = 1'b1; ifu_b.awaddr = 32'h3000_0000; ifu_b.awid = '0; ifu_b.awlen = '0;
        ifu_b.awsize = 3'd2; ifu_b.awburst = BURST_INCR; ifu_b.wvalid = 1'b1;
        ifu_b.wdata = 32'hBAD0_BAD0; ifu_b.wstrb = 4'hF; ifu_b.wlast = 1'b1; ifu_b.bready = 1'b1;
        ifu_b.arvalid = 1'b0; ifu_b.araddr = '0; ifu_b.arid = 4'h7; ifu_b.arlen = '0;
        ifu_b.arsize = 3'd2; ifu_b.arburst = BURST_INCR; ifu_b.rready = 1'b1;
        lsu_b.awvalid = 1'b0; lsu_b.awaddr = '0; lsu_b.awid = 4'h9; lsu_b.awlen = '0;
        lsu_b.awsize = 3'd2; lsu_b.awburst = BURST_INCR; lsu_b.wvalid = 1'b0; lsu_b.wdata = '0;
        lsu_b.wstrb = '0; lsu_b.wlast = 1'b0; lsu_b.bready = 1'b1;
        lsu_b.arvalid = 1'b0; lsu_b.araddr = '0; lsu_b.arid = 4'h9; lsu_b.arlen = '0;
        lsu_b.arsize = 3'd2; lsu_b.arburst = BURST_INCR; lsu_b.rready = 1'b1;
        axi_b.awready = 1'b0; axi_b.wready = 1'b0; axi_b.bvalid = 1'b0; axi_b.bresp = '0;
        axi_b.bid = '0; axi_b.arready = 1'b0; axi_b.rvalid = 1'b0; axi_b.rresp = '0;
        axi_b.rdata = '0; axi_b.rlast = 1'b0; axi_b.rid = '0;

        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // IFU fetch, then idle gap before the next grant.
        ifu_b.arvalid = 1'b1; ifu_b.araddr = 32'h3000_0000; ifu_b.arlen = 8'd0;
        run_read(1'b0, 32'h3000_0000, 4'h0, 1, 1, 32'h0000_0413, RESP_OKAY, 1'b0);
        ifu_b.arvalid = 1'b1; ifu_b.araddr = 32'h3000_0004;
        @(negedge clk);
        chk("idle_gap_arvalid", axi_b.arvalid, 32'h0);
        chk("idle_gap_arready", ifu_b.arready, 32'h0);
        run_read(1'b0, 32'h3000_0004, 4'h0, 0, 1, 32'h0000_0013, RESP_OKAY, 1'b0);

        // Simultaneous reads: LSU first, IFU next.
        ifu_b.arvalid = 1'b1; ifu_b.araddr = 32'h3000_0100;
        lsu_b.arvalid = 1'b1; lsu_b.araddr = 32'h8000_0000; lsu_b.arlen = 8'd0;
        run_read(1'b1, 32'h8000_0000, 4'h1, 0, 1, 32'h1111_0000, RESP_OKAY, 1'b0);
        run_read(1'b0, 32'h3000_0100, 4'h0, 0, 1, 32'h2222_0000, RESP_OKAY, 1'b0);

        // LSU 4-beat burst with IFU request raised mid-burst.
        lb0 = lsu_beats;
        lsu_b.arvalid = 1'b1; lsu_b.araddr = 32'ha000_0000; lsu_b.arlen = 8'd3;
        run_read(1'b1, 32'ha000_0000, 4'h1, 1, 4, 32'hA0A0_0000, RESP_OKAY, 1'b1);
        chk("lsu_burst_beats", lsu_beats - lb0, 32'd4);
        run_read(1'b0, 32'h3000_0200, 4'h0, 0, 1, 32'h3333_0000, RESP_OKAY, 1'b0);

        // Error response forwarded verbatim to IFU only.
        ifu_b.arvalid = 1'b1; ifu_b.araddr = 32'h3000_0400;
        run_read(1'b0, 32'h3000_0400, 4'h0, 0, 1, 32'h4444_0000, RESP_SLVERR, 1'b0);

        // LSU write: W accepted three cycles ahead of AW; IFU read waits behind it.
        aw0 = aw_hs_n; w0 = w_hs_n;
        lsu_b.awvalid = 1'b1; lsu_b.awaddr = 32'h0f00_0000; lsu_b.awlen = 8'd0;
        lsu_b.wvalid = 1'b1; lsu_b.wdata = 32'hDEAD_BEEF; lsu_b.wstrb = 4'hF; lsu_b.wlast = 1'b1;
        ifu_b.arvalid = 1'b1; ifu_b.araddr = 32'h3000_0500;
        wait_ev(1, "w");
        chk("w_data_lit", axi_b.wdata, 32'hDEAD_BEEF);
        chk("w_strb_lit", axi_b.wstrb, 32'hF);
        chk("aw_addr_lit", axi_b.awaddr, 32'h0f00_0000);
        chk("aw_id_lit", axi_b.awid, 32'h1);
        cyc();
        axi_b.wready = 1'b1;
        cyc();
        cyc();
        cyc();
        axi_b.awready = 1'b1;
        cyc();
        axi_b.awready = 1'b0; axi_b.wready = 1'b0;
        lsu_b.awvalid = 1'b0; lsu_b.wvalid = 1'b0;
        axi_b.bvalid = 1'b1; axi_b.bresp = RESP_OKAY;
        @(negedge clk);
        chk("b_to_lsu_lit", lsu_b.bvalid, 32'h1);
        chk("b_not_ifu_lit", ifu_b.bvalid, 32'h0);
        cyc();
        axi_b.bvalid = 1'b0;
        chk("aw_beats", aw_hs_n - aw0, 32'd1);
        chk("w_beats", w_hs_n - w0, 32'd1);
        run_read(1'b0, 32'h3000_0500, 4'h0, 0, 1, 32'h5555_0000, RESP_OKAY, 1'b0);

        // LSU write with AW and W together and a DECERR response.
        lsu_b.awvalid = 1'b1; lsu_b.awaddr = 32'h0f00_0010;
        lsu_b.wvalid = 1'b1; lsu_b.wdata = 32'h1234_5678; lsu_b.wstrb = 4'h3; lsu_b.wlast = 1'b1;
        wait_ev(2, "aw");
        cyc();
        axi_b.awready = 1'b1; axi_b.wready = 1'b1;
        cyc();
        axi_b.awready = 1'b0; axi_b.wready = 1'b0;
        lsu_b.awvalid = 1'b0; lsu_b.wvalid = 1'b0;
        axi_b.bvalid = 1'b1; axi_b.bresp = RESP_DECERR;
        @(negedge clk);
        chk("bresp_lit", lsu_b.bresp, 32'h3);
        cyc();
        axi_b.bvalid = 1'b0; axi_b.bresp = RESP_OKAY;

        // Reset during RD_DATA with a beat pending.
        ifu_b.arvalid = 1'b1; ifu_b.araddr = 32'h3000_0300;
        wait_ev(0, "ar_rst");
        cyc();
        axi_b.arready = 1'b1;
        cyc();
        axi_b.arready = 1'b0; ifu_b.arvalid = 1'b0;
        axi_b.rvalid = 1'b1; axi_b.rdata = 32'h0000_0123; axi_b.rlast = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_rvalid_lit", ifu_b.rvalid, 32'h0);
        cyc();
        rst = 1'b0; axi_b.rvalid = 1'b0; axi_b.rlast = 1'b0;
        @(negedge clk);
        chk("post_rst_idle_lit", {ifu_b.arready, axi_b.arvalid, axi_b.rready}, 32'h0);
        cyc();
        ifu_b.arvalid = 1'b1; ifu_b.araddr = 32'h3000_0600;
        run_read(1'b0, 32'h3000_0600, 4'h0, 0, 1, 32'h6666_0000, RESP_OKAY, 1'b0);

        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
